// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed 7-segment driver: splits a 4-bit value into tens/units
// and scans both digits from a local prescaler, updating only at frame boundaries.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter int unsigned ANODE_ACT_LOW = 1,
  parameter int unsigned SEG_ACT_LOW   = 1,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] value_in,
  input  logic       value_valid,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       scan_tick
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [1:0] AN_OFF  = (ANODE_ACT_LOW != 0) ? 2'b11 : 2'b00;
  localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic {
    UNITS = 1'b0,
    TENS  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          frame_end;
  logic [3:0]    pend_q;
  logic [3:0]    disp_q;
  logic [3:0]    disp_nxt;
  logic          tens;
  logic [3:0]    units;
  logic [1:0]    an_act;
  logic [6:0]    seg_pat;
  logic [1:0]    an_nxt;
  logic [6:0]    seg_nxt;

  // Active-high gfedcba pattern for a decimal digit.
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      scan_tick <= 1'b0;
    end else begin
      cnt       <= tick ? '0 : cnt + 1'b1;
      scan_tick <= tick;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= UNITS;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    case (state)
      UNITS: if (tick) state_nxt = TENS;
      TENS: begin
        if (tick) begin
          state_nxt = UNITS;
          frame_end = 1'b1;
        end
      end
      default: state_nxt = UNITS;
    endcase
  end

  // value_valid is a one-cycle strobe with no back-pressure: every strobe is
  // accepted into pend_q, and a strobe on the boundary cycle goes straight to disp_q.
  assign disp_nxt = value_valid ? value_in : pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      disp_q <= '0;
    end else begin
      if (value_valid) pend_q <= value_in;
      if (frame_end)   disp_q <= disp_nxt;
    end
  end

  assign tens  = (disp_q >= 4'd10);
  assign units = tens ? (disp_q - 4'd10) : disp_q;

  always_comb begin
    an_act  = 2'b00;
    seg_pat = 7'h00;
    case (state)
      UNITS: begin
        an_act  = 2'b01;
        seg_pat = seg_pattern(units);
      end
      TENS: begin
        if (!((BLANK_LEADING != 0) && !tens)) begin
          an_act  = 2'b10;
          seg_pat = seg_pattern({3'b000, tens});
        end
      end
      default: begin
        an_act  = 2'b00;
        seg_pat = 7'h00;
      end
    endcase
    an_nxt  = (ANODE_ACT_LOW != 0) ? ~an_act : an_act;
    seg_nxt = (SEG_ACT_LOW != 0) ? ~seg_pat : seg_pat;
  end

  // Only one digit is selected per state and the state changes at most once per
  // cycle, so the registered anodes can never both be active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4; instance a blanks the
// leading zero, instance b does not.
module tb_seg7_scan_driver;

  logic       clk;
  logic       rst;
  logic [3:0] value_a, value_b;
  logic       valid_a, valid_b;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       tick_a, tick_b;

  int checks = 0;
  int errors = 0;
  int ec = 0;

  seg7_scan_driver #(.REFRESH_DIV(4), .ANODE_ACT_LOW(1), .SEG_ACT_LOW(1), .BLANK_LEADING(1)) u_a (
    .clk(clk), .rst(rst), .value_in(value_a), .value_valid(valid_a),
    .seg(seg_a), .an(an_a), .scan_tick(tick_a)
  );

  seg7_scan_driver #(.REFRESH_DIV(4), .ANODE_ACT_LOW(1), .SEG_ACT_LOW(1), .BLANK_LEADING(0)) u_b (
    .clk(clk), .rst(rst), .value_in(value_b), .value_valid(valid_b),
    .seg(seg_b), .an(an_b), .scan_tick(tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, ec);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ec++;
  endtask

  task automatic goto(input int e);
    while (ec < e) step();
  endtask

  task automatic strobe_a(input logic [3:0] v);
    value_a = v;
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
  endtask

  task automatic strobe_b(input logic [3:0] v);
    value_b = v;
    valid_b = 1'b1;
    step();
    valid_b = 1'b0;
  endtask

  // Break-before-make on both instances, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("an_a_overlap", {6'd0, (an_a == 2'b00)}, 8'd0);
      chk("an_b_overlap", {6'd0, (an_b == 2'b00)}, 8'd0);
    end
  end

  initial begin
    rst = 1'b1;
    value_a = 4'd0; valid_a = 1'b0;
    value_b = 4'd0; valid_b = 1'b0;
    #1;
    chk("rst_an", {6'd0, an_a}, 8'h03);
    chk("rst_seg", {1'b0, seg_a}, 8'h7F);
    chk("rst_tick", {7'd0, tick_a}, 8'h00);
    #1 rst = 1'b0;

    // First edge after release: units digit shows 0
    goto(1);
    chk("e1_an", {6'd0, an_a}, 8'h02);
    chk("e1_seg", {1'b0, seg_a}, 8'h40);

    // Test 1: value 7
    strobe_a(4'd7);
    goto(4);
    chk("t1_tick4", {7'd0, tick_a}, 8'h01);
    goto(8);
    chk("t1_old_tens_an", {6'd0, an_a}, 8'h03);
    goto(9);
    chk("t1_units_seg", {1'b0, seg_a}, 8'h78);
    chk("t1_units_an", {6'd0, an_a}, 8'h02);

    // Test 2: value 13
    goto(10);
    strobe_a(4'd13);
    goto(12);
    chk("t1_tick12", {7'd0, tick_a}, 8'h01);
    goto(13);
    chk("t1_tens_an", {6'd0, an_a}, 8'h03);
    chk("t1_tens_seg", {1'b0, seg_a}, 8'h7F);
    chk("t1_tick13", {7'd0, tick_a}, 8'h00);
    goto(17);
    chk("t2_units_seg", {1'b0, seg_a}, 8'h30);
    chk("t2_units_an", {6'd0, an_a}, 8'h02);

    // Test 3 preload: 5 pending for the next frame
    strobe_a(4'd5);
    goto(20);
    chk("t2_units_seg_end", {1'b0, seg_a}, 8'h30);
    chk("t2_tick20", {7'd0, tick_a}, 8'h01);
    goto(21);
    chk("t2_tens_seg", {1'b0, seg_a}, 8'h79);
    chk("t2_tens_an", {6'd0, an_a}, 8'h01);
    chk("t2_tick21", {7'd0, tick_a}, 8'h00);
    goto(24);
    chk("t2_tens_an_end", {6'd0, an_a}, 8'h01);
    chk("t2_tick24", {7'd0, tick_a}, 8'h01);

    // Test 3: 5 shown, 12 strobed mid-units slot
    goto(25);
    chk("t3_five_seg", {1'b0, seg_a}, 8'h12);
    strobe_a(4'd12);
    chk("t3_hold_seg26", {1'b0, seg_a}, 8'h12);
    goto(28);
    chk("t3_hold_seg28", {1'b0, seg_a}, 8'h12);
    goto(29);
    chk("t3_blank_an", {6'd0, an_a}, 8'h03);
    chk("t3_blank_seg", {1'b0, seg_a}, 8'h7F);
    goto(32);
    chk("t3_blank_an32", {6'd0, an_a}, 8'h03);
    goto(33);
    chk("t3_twelve_seg", {1'b0, seg_a}, 8'h24);
    chk("t3_twelve_an", {6'd0, an_a}, 8'h02);
    goto(37);
    chk("t3_twelve_tens_seg", {1'b0, seg_a}, 8'h79);
    chk("t3_twelve_tens_an", {6'd0, an_a}, 8'h01);

    // Test 4: strobe 9 exactly on the boundary edge (E40)
    goto(39);
    strobe_a(4'd9);
    chk("t4_boundary_an", {6'd0, an_a}, 8'h01);
    goto(41);
    chk("t4_bypass_seg", {1'b0, seg_a}, 8'h10);
    strobe_a(4'd3);
    goto(43);
    strobe_a(4'd8);
    goto(45);
    chk("t4_nine_blank_an", {6'd0, an_a}, 8'h03);
    goto(49);
    chk("t4_eight_seg", {1'b0, seg_a}, 8'h00);
    chk("t4_eight_an", {6'd0, an_a}, 8'h02);

    // Test 5: value 11, reset during its tens slot with a value pending
    strobe_a(4'd11);
    goto(52);
    chk("t4_eight_seg52", {1'b0, seg_a}, 8'h00);
    goto(57);
    chk("t5_units_seg", {1'b0, seg_a}, 8'h79);
    chk("t5_units_an", {6'd0, an_a}, 8'h02);
    goto(61);
    strobe_a(4'd6);
    chk("t5_tens_an", {6'd0, an_a}, 8'h01);
    chk("t5_tens_seg", {1'b0, seg_a}, 8'h79);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_an", {6'd0, an_a}, 8'h03);
    chk("t5_async_seg", {1'b0, seg_a}, 8'h7F);
    chk("t5_async_tick", {7'd0, tick_a}, 8'h00);
    chk("t5_async_an_b", {6'd0, an_b}, 8'h03);
    @(negedge clk);
    rst = 1'b0;
    ec = 0;

    goto(1);
    chk("t5_restart_an", {6'd0, an_a}, 8'h02);
    chk("t5_restart_seg", {1'b0, seg_a}, 8'h40);
    strobe_b(4'd4);
    goto(3);
    chk("t5_tick3", {7'd0, tick_a}, 8'h00);
    goto(4);
    chk("t5_tick4", {7'd0, tick_a}, 8'h01);
    goto(5);
    chk("t5_tens_blank_an", {6'd0, an_a}, 8'h03);
    chk("t6_zero_tens_an", {6'd0, an_b}, 8'h01);
    chk("t6_zero_tens_seg", {1'b0, seg_b}, 8'h40);
    goto(9);
    chk("t5_pend_lost_seg", {1'b0, seg_a}, 8'h40);
    chk("t5_pend_lost_an", {6'd0, an_a}, 8'h02);
    chk("t6_units_seg", {1'b0, seg_b}, 8'h19);
    chk("t6_units_an", {6'd0, an_b}, 8'h02);

    // Test 6: tens digit 0 is shown, not blanked
    goto(13);
    chk("t6_tens_an", {6'd0, an_b}, 8'h01);
    chk("t6_tens_seg", {1'b0, seg_b}, 8'h40);
    chk("t6_a_blank_an", {6'd0, an_a}, 8'h03);

    goto(16);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
